// File: rtl/uart_tx_responder.sv
// UART transmitter behind a level request/ack handshake: sends exactly one
// start/8 data/optional parity/stop frame per i_ready assertion, o_next marks the send.
module uart_tx_responder #(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic [7:0] i_data,
  input  logic       i_ready,
  output logic       o_next,
  output logic       o_tx,
  output logic [2:0] d_state,
  output logic [3:0] d_bit
);

  localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_PARITY  = 3'd3,
    S_STOP    = 3'd4,
    S_RELEASE = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          stop_q, stop_d;
  logic          tx_q, tx_d;
  logic          next_q, next_d;
  logic          bit_done;
  logic          par_bit;

  assign bit_done = (cnt_q == CNT_LAST);
  assign par_bit  = (PARITY == 2) ? ~par_q : par_q;

  always_comb begin
    // NOTE: every next-state variable gets a hold default first; a path that
    // skips an assignment would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    stop_d  = stop_q;
    tx_d    = tx_q;
    next_d  = next_q;

    if (i_en) begin
      // All bit states share one baud counter that wraps at the end of each bit.
      if (state_q inside {S_START, S_DATA, S_PARITY, S_STOP})
        cnt_d = bit_done ? '0 : cnt_q + 1'b1;

      case (state_q)
        S_IDLE: begin
          tx_d   = 1'b1;
          next_d = 1'b0;
          if (i_ready) begin
            shift_d = i_data;
            par_d   = ^i_data;
            next_d  = 1'b1;
            tx_d    = 1'b0;
            cnt_d   = '0;
            state_d = S_START;
          end
        end
        S_START: begin
          if (bit_done) begin
            bit_d   = '0;
            tx_d    = shift_q[0];
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          if (bit_done) begin
            if (bit_q == 3'd7) begin
              bit_d = '0;
              if (PARITY != 0) begin
                tx_d    = par_bit;
                state_d = S_PARITY;
              end else begin
                tx_d    = 1'b1;
                stop_d  = 1'b0;
                state_d = S_STOP;
              end
            end else begin
              bit_d   = bit_q + 1'b1;
              shift_d = shift_q >> 1;
              tx_d    = shift_q[1];
            end
          end
        end
        S_PARITY: begin
          if (bit_done) begin
            tx_d    = 1'b1;
            stop_d  = 1'b0;
            state_d = S_STOP;
          end
        end
        S_STOP: begin
          if (bit_done) begin
            if (stop_q == STOP_LAST) begin
              next_d  = 1'b0;
              state_d = i_ready ? S_RELEASE : S_IDLE;
            end else begin
              stop_d = stop_q + 1'b1;
            end
          end
        end
        S_RELEASE: begin
          // A still-high request belongs to the frame just sent; wait for it to drop.
          tx_d   = 1'b1;
          next_d = 1'b0;
          if (!i_ready) state_d = S_IDLE;
        end
        default: begin
          tx_d    = 1'b1;
          next_d  = 1'b0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      stop_q  <= 1'b0;
      tx_q    <= 1'b1;
      next_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
      next_q  <= next_d;
    end
  end

  assign o_tx    = tx_q;
  assign o_next  = next_q;
  assign d_state = state_q;
  assign d_bit   = {1'b0, bit_q};

endmodule

// File: tb/tb_uart_tx_responder.sv
// Bench for uart_tx_responder: three instances (no parity/1 stop, even/1 stop,
// odd/2 stop); a per-instance monitor compares each captured frame with a queued model.
module tb_uart_tx_responder;

  localparam int CPB = 4;

  typedef struct {
    int           inst;
    int           len;
    logic [127:0] wave;
  } frame_t;

  logic       clk;
  logic [2:0] rst_n;
  logic [2:0] en;
  logic [2:0] ready;
  logic [7:0] data [3];
  logic [2:0] next;
  logic [2:0] tx;
  logic [2:0] st   [3];
  logic [3:0] dbit [3];

  frame_t exp_q [$];
  int     n_checks = 0;
  int     n_fail   = 0;

  initial clk = 1'b0;
  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void add(inout frame_t f, input logic b, input int n);
    for (int k = 0; k < n; k++) begin
      f.wave[f.len[6:0]] = b;
      f.len++;
    end
  endfunction

  // Expected o_tx per cycle while o_next is high; instance g has PARITY=g,
  // and instance 2 uses two stop bits. A stalled data bit is 10 cycles longer.
  function automatic frame_t build(input int g, input logic [7:0] d, input int stall_bit);
    frame_t f;
    f.inst = g;
    f.len  = 0;
    f.wave = '0;
    add(f, 1'b0, CPB);
    for (int i = 0; i < 8; i++) add(f, d[i], (i == stall_bit) ? CPB + 10 : CPB);
    if (g == 1) add(f, ^d, CPB);
    else if (g == 2) add(f, ~^d, CPB);
    add(f, 1'b1, (g == 2) ? 2 * CPB : CPB);
    return f;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    uart_tx_responder #(
      .CLKS_PER_BIT(CPB),
      .PARITY      (g),
      .STOP_BITS   ((g == 2) ? 2 : 1)
    ) u_dut (
      .i_clk  (clk),
      .i_rst_n(rst_n[g]),
      .i_en   (en[g]),
      .i_data (data[g]),
      .i_ready(ready[g]),
      .o_next (next[g]),
      .o_tx   (tx[g]),
      .d_state(st[g]),
      .d_bit  (dbit[g])
    );

    initial begin : mon
      logic         prev;
      int           n;
      logic [127:0] w;
      frame_t       e;
      prev = 1'b0;
      n    = 0;
      w    = '0;
      forever begin
        @(negedge clk);
        if (!rst_n[g]) begin
          prev = 1'b0;
        end else if (next[g]) begin
          if (!prev) begin
            n = 0;
            w = '0;
          end
          if (n < 128) w[n[6:0]] = tx[g];
          n++;
          prev = 1'b1;
        end else if (prev) begin
          prev = 1'b0;
          check($sformatf("inst%0d_frame_expected", g), 128'(exp_q.size() != 0), 128'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check($sformatf("inst%0d_frame_owner", g), 128'(g), 128'(e.inst));
            check($sformatf("inst%0d_next_high_cycles", g), 128'(n), 128'(e.len));
            check($sformatf("inst%0d_tx_wave", g), w, e.wave);
          end
        end
      end
    end
  end

  // Producer: raise request, confirm 1-cycle acceptance, corrupt data mid-frame,
  // optionally stall a data bit, wait for o_next to fall, then drop the request.
  task automatic send_frame(input int g, input logic [7:0] d, input int stall_bit,
                            input int extra_hold);
    logic ok;
    int   hi;
    exp_q.push_back(build(g, d, stall_bit));
    data[g]  = d;
    ready[g] = 1'b1;
    check("pre_accept_next", 128'(next[g]), 128'd0);
    @(negedge clk);
    check("accept_next", 128'(next[g]), 128'd1);
    check("accept_tx_start", 128'(tx[g]), 128'd0);
    check("accept_state", 128'(st[g]), 128'd1);
    data[g] = 8'hFF;
    if (stall_bit >= 0) begin
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
        if (st[g] == 3'd2 && dbit[g] == 4'(stall_bit)) begin
          ok = 1'b1;
          break;
        end
        @(negedge clk);
      end
      check("stall_bit_reached", 128'(ok), 128'd1);
      en[g] = 1'b0;
      repeat (10) @(negedge clk);
      check("frozen_bit", 128'(dbit[g]), 128'(stall_bit));
      check("frozen_state", 128'(st[g]), 128'd2);
      en[g] = 1'b1;
    end
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!next[g]) begin
        ok = 1'b1;
        break;
      end
    end
    check("next_fall_seen", 128'(ok), 128'd1);
    if (extra_hold > 0) begin
      hi = 0;
      for (int i = 0; i < extra_hold; i++) begin
        @(negedge clk);
        if (next[g]) hi++;
      end
      check("held_ready_no_refire", 128'(hi), 128'd0);
      check("held_state_release", 128'(st[g]), 128'd5);
    end
    ready[g] = 1'b0;
    @(negedge clk);
    check("rearm_idle", 128'(st[g]), 128'd0);
    check("rearm_tx_idle", 128'(tx[g]), 128'd1);
  endtask

  initial begin : stim
    logic ok;
    rst_n = 3'b000;
    en    = 3'b111;
    ready = 3'b000;
    for (int g = 0; g < 3; g++) data[g] = 8'h00;
    #12;
    for (int g = 0; g < 3; g++) begin
      check($sformatf("reset_tx%0d", g), 128'(tx[g]), 128'd1);
      check($sformatf("reset_next%0d", g), 128'(next[g]), 128'd0);
      check($sformatf("reset_state%0d", g), 128'(st[g]), 128'd0);
      check($sformatf("reset_bit%0d", g), 128'(dbit[g]), 128'd0);
    end
    @(negedge clk);
    rst_n = 3'b111;
    @(negedge clk);

    // Basic frame, request then held high for 100 cycles: one frame only.
    send_frame(0, 8'h41, -1, 100);
    // Back-to-back requests separated by a single low cycle.
    send_frame(0, 8'h08, -1, 0);
    send_frame(0, 8'h20, -1, 0);
    send_frame(0, 8'h08, -1, 0);
    // Even parity, then odd parity with two stop bits.
    send_frame(1, 8'h07, -1, 0);
    send_frame(2, 8'h07, -1, 0);
    // Clock enable held low for 10 cycles inside data bit 2.
    send_frame(0, 8'hA5, 2, 0);

    // Asynchronous reset in data bit 3 abandons the frame at once.
    data[0]  = 8'hF0;
    ready[0] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (st[0] == 3'd2 && dbit[0] == 4'd3) begin
        ok = 1'b1;
        break;
      end
    end
    check("pre_reset_bit3", 128'(ok), 128'd1);
    check("pre_reset_tx", 128'(tx[0]), 128'd0);
    #1 rst_n[0] = 1'b0;
    #1;
    check("async_reset_tx", 128'(tx[0]), 128'd1);
    check("async_reset_next", 128'(next[0]), 128'd0);
    check("async_reset_state", 128'(st[0]), 128'd0);
    check("async_reset_bit", 128'(dbit[0]), 128'd0);
    ready[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n[0] = 1'b1;
    @(negedge clk);
    send_frame(0, 8'h55, -1, 0);

    send_frame(2, 8'hC3, -1, 0);
    send_frame(1, 8'h80, -1, 0);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
